// File: rtl/mod_compressor_pkg.sv
// ============================================================================
// Module  : mod_compressor_pkg
// Brief   : Shared word width and SHA-256 round/schedule logic functions.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mod_compressor_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    function automatic word_t rotr(input word_t x, input int n);
        rotr = (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        big_sigma0 = rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        big_sigma1 = rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        small_sigma0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        small_sigma1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        ch = (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        maj = (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod_msg_schedule.sv
// ============================================================================
// Module  : mod_msg_schedule
// Brief   : 16-word SHA-256 message schedule window with Wt select/expand.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mod_msg_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [5:0]  i_idx,
    input  logic [31:0] i_w,
    output logic [31:0] o_wt
);
    import mod_compressor_pkg::*;

    // r_win[15] holds W[t-1], r_win[0] holds W[t-16]
    word_t r_win [16];
    word_t w_expand;
    word_t w_wt;

    always_comb begin
        w_expand = small_sigma1(r_win[14]) + r_win[9]
                 + small_sigma0(r_win[1]) + r_win[0];
        w_wt     = (i_idx < 6'd16) ? i_w : w_expand;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= '0;
            end
        end else if (i_en) begin
            for (int i = 0; i < 15; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[15] <= w_wt;
        end
    end

    assign o_wt = w_wt;

endmodule

`default_nettype wire

// File: rtl/mod_compressor.sv
// ============================================================================
// Module  : mod_compressor
// Brief   : One SHA-256 compression round per enabled clock; I==0 reloads H.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mod_compressor #(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              EN,
    input  logic [5:0]        I,
    input  logic [WORD_W-1:0] W_IN,
    input  logic [WORD_W-1:0] K_IN,
    input  logic [WORD_W-1:0] H0,
    input  logic [WORD_W-1:0] H1,
    input  logic [WORD_W-1:0] H2,
    input  logic [WORD_W-1:0] H3,
    input  logic [WORD_W-1:0] H4,
    input  logic [WORD_W-1:0] H5,
    input  logic [WORD_W-1:0] H6,
    input  logic [WORD_W-1:0] H7,
    output logic [WORD_W-1:0] a,
    output logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] c,
    output logic [WORD_W-1:0] d,
    output logic [WORD_W-1:0] e,
    output logic [WORD_W-1:0] f,
    output logic [WORD_W-1:0] g,
    output logic [WORD_W-1:0] h
);
    import mod_compressor_pkg::*;

    word_t r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
    word_t w_sa, w_sb, w_sc, w_sd, w_se, w_sf, w_sg, w_sh;
    word_t w_wt, w_t1, w_t2;
    logic  w_load;

    mod_msg_schedule u_sched (
        .clk   (CLK),
        .rst   (RESET),
        .i_en  (EN),
        .i_idx (I),
        .i_w   (W_IN),
        .o_wt  (w_wt)
    );

    // Round 0 sources the chaining value directly, so no separate load cycle
    assign w_load = (I == 6'd0);

    always_comb begin
        w_sa = w_load ? H0 : r_a;
        w_sb = w_load ? H1 : r_b;
        w_sc = w_load ? H2 : r_c;
        w_sd = w_load ? H3 : r_d;
        w_se = w_load ? H4 : r_e;
        w_sf = w_load ? H5 : r_f;
        w_sg = w_load ? H6 : r_g;
        w_sh = w_load ? H7 : r_h;
        w_t1 = w_sh + big_sigma1(w_se) + ch(w_se, w_sf, w_sg) + K_IN + w_wt;
        w_t2 = big_sigma0(w_sa) + maj(w_sa, w_sb, w_sc);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
            r_d <= '0;
            r_e <= '0;
            r_f <= '0;
            r_g <= '0;
            r_h <= '0;
        end else if (EN) begin
            r_a <= w_t1 + w_t2;
            r_b <= w_sa;
            r_c <= w_sb;
            r_d <= w_sc;
            r_e <= w_sd + w_t1;
            r_f <= w_se;
            r_g <= w_sf;
            r_h <= w_sg;
        end
    end

    assign a = r_a;
    assign b = r_b;
    assign c = r_c;
    assign d = r_d;
    assign e = r_e;
    assign f = r_f;
    assign g = r_g;
    assign h = r_h;

endmodule

`default_nettype wire

// File: tb/tb_mod_compressor.sv
// ============================================================================
// Module  : tb_mod_compressor
// Brief   : Directed self-checking bench for the SHA-256 round block.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mod_compressor;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        EN;
    logic [5:0]  I;
    logic [31:0] W_IN, K_IN;
    logic [255:0] r_hv;
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [255:0] w_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    assign w_out = {a, b, c, d, e, f, g, h};

    mod_compressor #(.WORD_W(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (EN),
        .I     (I),
        .W_IN  (W_IN),
        .K_IN  (K_IN),
        .H0    (r_hv[255:224]),
        .H1    (r_hv[223:192]),
        .H2    (r_hv[191:160]),
        .H3    (r_hv[159:128]),
        .H4    (r_hv[127:96]),
        .H5    (r_hv[95:64]),
        .H6    (r_hv[63:32]),
        .H7    (r_hv[31:0]),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .e     (e),
        .f     (f),
        .g     (g),
        .h     (h)
    );

    logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [31:0] MSG [16] = '{
        32'h48656C6C, 32'h6F20776F, 32'h726C6421, 32'h80000000,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h00000060
    };

    localparam logic [255:0] IV =
        {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
         32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] EXP62 =
        {32'h274FF178, 32'h56BA1F93, 32'h9E1C034F, 32'h5DEBB9F3,
         32'h13BAF643, 32'hDD37A448, 32'hBEF91801, 32'h33C2C571};
    localparam logic [255:0] EXP63 =
        {32'h564977E4, 32'h274FF178, 32'h56BA1F93, 32'h9E1C034F,
         32'hE03FF7C0, 32'h13BAF643, 32'hDD37A448, 32'hBEF91801};
    localparam logic [255:0] DIGEST =
        {32'hc0535e4b, 32'he2b79ffd, 32'h93291305, 32'h436bf889,
         32'h314e4a3f, 32'haec05ecf, 32'hfcbb7df3, 32'h1ad9e51a};

    typedef struct packed {
        logic [255:0] hv;
        logic [31:0]  w;
        logic [31:0]  k;
        logic [255:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_round(input logic [5:0] idx, input logic [31:0] w, input logic [31:0] k);
        EN   = 1'b1;
        I    = idx;
        W_IN = w;
        K_IN = k;
        @(posedge CLK);
        #1;
        EN = 1'b0;
    endtask

    // Runs rounds 0..last of the "Hello world!" block, optionally with
    // garbage W_IN past round 15 and a 3-cycle EN=0 gap after pause_after.
    task automatic run_block(input bit garbage, input int pause_after, input int last);
        r_hv = IV;
        for (int t = 0; t <= last; t++) begin
            do_round(6'(t), (t < 16) ? MSG[t] : (garbage ? 32'hFFFFFFFF : 32'h0), KT[t]);
            if (t == pause_after) begin
                EN   = 1'b0;
                I    = 6'd0;
                W_IN = 32'hFFFFFFFF;
                K_IN = 32'hFFFFFFFF;
                repeat (3) @(posedge CLK);
                #1;
            end
        end
    endtask

    task automatic check_full(input string tag, input bit garbage, input int pause_after);
        logic [255:0] sum;
        run_block(garbage, pause_after, 62);
        check({tag, "_r62"}, w_out, EXP62);
        do_round(6'd63, garbage ? 32'hFFFFFFFF : 32'h0, KT[63]);
        check({tag, "_r63"}, w_out, EXP63);
        for (int j = 0; j < 8; j++) begin
            sum[j*32 +: 32] = IV[j*32 +: 32] + w_out[j*32 +: 32];
        end
        check({tag, "_digest"}, sum, DIGEST);
    endtask

    initial begin
        vecs[0] = '{hv: 256'h0, w: 32'h1, k: 32'h0,
                    exp: {32'h1, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0}};
        vecs[1] = '{hv: 256'h0, w: 32'h0, k: 32'h5,
                    exp: {32'h5, 32'h0, 32'h0, 32'h0, 32'h5, 32'h0, 32'h0, 32'h0}};
        vecs[2] = '{hv: {32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0, 32'h0},
                    w: 32'h0, k: 32'h0,
                    exp: {32'h12345677, 32'h0, 32'h0, 32'h0, 32'h12345677, 32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0}};
        vecs[3] = '{hv: {32'h0, 32'h0, 32'h0, 32'h00000100, 32'h0, 32'h11111111, 32'h22222222, 32'h00000010},
                    w: 32'h0, k: 32'h0,
                    exp: {32'h22222232, 32'h0, 32'h0, 32'h0, 32'h22222332, 32'h0, 32'h11111111, 32'h22222222}};
        vecs[4] = '{hv: {32'hFFFFFFFF, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                    w: 32'h0, k: 32'h0,
                    exp: {32'h0FFF0FFE, 32'hFFFFFFFF, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0, 32'h0, 32'h0, 32'h0}};
        vecs[5] = '{hv: 256'h0, w: 32'hFFFFFFFF, k: 32'h2,
                    exp: {32'h1, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0}};

        RESET = 1'b1;
        EN    = 1'b0;
        I     = 6'd0;
        W_IN  = 32'h0;
        K_IN  = 32'h0;
        r_hv  = 256'h0;
        @(posedge CLK);
        #1;
        check("reset_state", w_out, 256'h0);
        RESET = 1'b0;

        // Single I=0 rounds from a chosen chaining value
        for (int v = 0; v < 6; v++) begin
            r_hv = vecs[v].hv;
            do_round(6'd0, vecs[v].w, vecs[v].k);
            check($sformatf("vec%0d", v), w_out, vecs[v].exp);
        end

        // I=1 must continue from registers, not from H
        r_hv = 256'h0;
        do_round(6'd0, 32'h1, 32'h0);
        r_hv = IV;
        do_round(6'd1, 32'h0, 32'h0);
        check("round1_from_regs", w_out,
              {32'h44280480, 32'h1, 32'h0, 32'h0, 32'h04200080, 32'h1, 32'h0, 32'h0});

        // Asynchronous reset between edges, EN ignored while held
        #1;
        RESET = 1'b1;
        #1;
        check("async_reset", w_out, 256'h0);
        EN = 1'b1;
        I  = 6'd0;
        repeat (2) @(posedge CLK);
        #1;
        check("en_ignored_in_reset", w_out, 256'h0);
        EN    = 1'b0;
        #2;
        RESET = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check("hold_after_reset", w_out, 256'h0);

        check_full("hello", 1'b0, -1);
        check_full("paused", 1'b0, 20);
        check_full("garbage", 1'b1, -1);
        check_full("garbage_again", 1'b1, -1);

        // Restart mid-block with I=0
        run_block(1'b0, -1, 30);
        run_block(1'b0, -1, 62);
        check("restart_mid_r62", w_out, EXP62);

        // Reset mid-block aborts, next block resumes from I=0
        run_block(1'b0, -1, 10);
        #1;
        RESET = 1'b1;
        #1;
        check("reset_mid_block", w_out, 256'h0);
        #2;
        RESET = 1'b0;
        run_block(1'b0, -1, 62);
        check("after_reset_r62", w_out, EXP62);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
